// File: rtl/iob_rsp_route.sv
// Forwards merged IOb requests to a shared slave and steers in-order read
// responses back to the requester recorded in a small ID FIFO.
module iob_rsp_route #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  parameter  int N      = 2,
  parameter  int DEPTH  = 4,
  localparam int NBITS  = $clog2(N) + ($clog2(N) == 0),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  s_avalid_i,
  input  logic [ADDR_W-1:0]     s_addr_i,
  input  logic [DATA_W-1:0]     s_wdata_i,
  input  logic [DATA_W/8-1:0]   s_wstrb_i,
  input  logic [NBITS-1:0]      s_id_i,
  output logic                  s_ready_o,
  output logic [N*DATA_W-1:0]   s_rdata_o,
  output logic [N-1:0]          s_rvalid_o,
  output logic                  m_avalid_o,
  output logic [ADDR_W-1:0]     m_addr_o,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [DATA_W/8-1:0]   m_wstrb_o,
  input  logic                  m_ready_i,
  input  logic [DATA_W-1:0]     m_rdata_i,
  input  logic                  m_rvalid_i,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [NBITS-1:0] id_mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;

  logic             is_rd;
  logic             empty;
  logic             full;
  logic             pop;
  logic             blk;
  logic             push;
  logic [NBITS-1:0] head;
  logic [N-1:0]     sel;

  assign is_rd = (s_wstrb_i == '0);
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign pop   = m_rvalid_i & cke_i & ~empty;
  // A full FIFO still takes a read when a response frees a slot this cycle.
  assign blk   = is_rd & full & ~pop;

  assign m_avalid_o = s_avalid_i & cke_i & ~blk;
  assign s_ready_o  = m_ready_i & cke_i & ~blk;
  assign push       = s_avalid_i & s_ready_o & is_rd;

  assign m_addr_o  = s_addr_i;
  assign m_wdata_o = s_wdata_i;
  assign m_wstrb_o = s_wstrb_i;

  assign outstanding_o = count_reg;
  assign err_o         = err_reg;

  // Head comes from registered FIFO storage, so routing never depends on s_id_i.
  assign head = id_mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign sel[gi] = pop & (head == NBITS'(gi));
      assign s_rvalid_o[gi] = sel[gi];
      assign s_rdata_o[gi*DATA_W +: DATA_W] = sel[gi] ? m_rdata_i : '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_reg[i] <= '0;
      end
    end else if (cke_i) begin
      if (push) begin
        id_mem_reg[wr_ptr_reg] <= s_id_i;
        wr_ptr_reg             <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Sticky: a response with nothing outstanding, or while frozen, is dropped.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      err_reg <= 1'b0;
    end else if (m_rvalid_i && (!cke_i || empty)) begin
      err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_rsp_route.sv
// Randomized and directed bench for iob_rsp_route with a queue-based
// reference model and a negedge monitor acting as scoreboard.
module tb_iob_rsp_route;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int NB    = 2;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            cke = 1'b1;
  logic            s_avalid = 1'b0;
  logic [AW-1:0]   s_addr = '0;
  logic [DW-1:0]   s_wdata = '0;
  logic [DW/8-1:0] s_wstrb = '0;
  logic [NB-1:0]   s_id = '0;
  logic            s_ready;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_rvalid;
  logic            m_avalid;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_ready = 1'b1;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_rvalid = 1'b0;
  logic [CW-1:0]   outstanding;
  logic            err;

  int errors = 0;
  int checks = 0;

  // Reference model: requester IDs of accepted, unanswered reads, oldest first.
  int exp_q[$];
  bit err_m = 1'b0;

  always #5 clk = ~clk;

  iob_rsp_route #(.DATA_W(DW), .ADDR_W(AW), .N(N), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .s_avalid_i(s_avalid), .s_addr_i(s_addr), .s_wdata_i(s_wdata),
    .s_wstrb_i(s_wstrb), .s_id_i(s_id), .s_ready_o(s_ready),
    .s_rdata_o(s_rdata), .s_rvalid_o(s_rvalid),
    .m_avalid_o(m_avalid), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_wstrb_o(m_wstrb), .m_ready_i(m_ready), .m_rdata_i(m_rdata),
    .m_rvalid_i(m_rvalid), .outstanding_o(outstanding), .err_o(err)
  );

  task automatic check(input string name, input logic [N*DW-1:0] act,
                       input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares once per cycle, then advances the model.
  always @(negedge clk) begin
    bit rd, pop, blk, rdy, av;
    logic [N-1:0]    exp_rv;
    logic [N*DW-1:0] exp_rd;
    int sz, id;
    if (!arst_n) begin
      exp_q.delete();
      err_m = 1'b0;
      check("rst_outstanding", outstanding, 0);
      check("rst_err", err, 0);
      check("rst_rvalid", s_rvalid, 0);
      check("rst_rdata", s_rdata, 0);
      check("rst_ready", s_ready, m_ready & cke);
    end else begin
      sz  = exp_q.size();
      rd  = (s_wstrb == 0);
      pop = m_rvalid && cke && (sz != 0);
      blk = rd && (sz == DEPTH) && !pop;
      rdy = m_ready && cke && !blk;
      av  = s_avalid && cke && !blk;
      exp_rv = '0;
      exp_rd = '0;
      if (pop) begin
        id = exp_q[0];
        exp_rv[id] = 1'b1;
        exp_rd[id*DW +: DW] = m_rdata;
      end
      check("s_ready", s_ready, rdy);
      check("m_avalid", m_avalid, av);
      check("m_addr", m_addr, s_addr);
      check("m_wstrb", m_wstrb, s_wstrb);
      check("s_rvalid", s_rvalid, exp_rv);
      check("s_rdata", s_rdata, exp_rd);
      check("outstanding", outstanding, sz);
      check("err", err, err_m);
      $display("cyc t=%0t av=%0b id=%0d rd=%0b rv=%0b ready=%0b s_rvalid=%b out=%0d err=%0b",
               $time, s_avalid, s_id, rd, m_rvalid, s_ready, s_rvalid, outstanding, err);
      if (pop) void'(exp_q.pop_front());
      if (m_rvalid && (!cke || sz == 0)) err_m = 1'b1;
      if (s_avalid && rdy && rd) exp_q.push_back(int'(s_id));
    end
  end

  task automatic step(input bit av, input int id, input logic [3:0] strb,
                      input bit rv, input logic [DW-1:0] rdat);
    s_avalid = av;
    s_id     = NB'(id);
    s_wstrb  = strb;
    s_addr   = $urandom;
    s_wdata  = $urandom;
    m_rvalid = rv;
    m_rdata  = rdat;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input int id);
    step(1'b1, id, 4'h0, 1'b0, '0);
  endtask

  task automatic rsp(input logic [DW-1:0] d);
    step(1'b0, 0, 4'h0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 0, 4'h0, 1'b0, '0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    idle();
    idle();
    arst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle();
    idle();
    arst_n = 1'b1;
    idle();
    idle();

    // In-order routing, requesters 2, 0, 3.
    rd_req(2); rd_req(0); rd_req(3); idle();
    rsp(32'hA); rsp(32'hB); rsp(32'hC); idle();

    // Fill, stall a fifth read, then accept it alongside a response.
    rd_req(1); rd_req(2); rd_req(3); rd_req(0);
    rd_req(1); rd_req(1);
    step(1'b1, 1, 4'h0, 1'b1, 32'h11);

    // Writes pass straight through while full.
    for (int i = 0; i < 10; i++) step(1'b1, i % N, 4'hF, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) rsp($urandom);
    idle();

    // Spurious response sets the sticky error.
    rsp(32'h55);
    rd_req(3); rsp(32'h66); idle();

    // Reset mid-operation drops outstanding IDs; a late response errors.
    rd_req(0); rd_req(1);
    do_reset();
    idle();
    rsp(32'h77);
    idle();
    do_reset();

    // Randomized traffic with stalls, writes and clock-enable gaps.
    for (int i = 0; i < 600; i++) begin
      cke     = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 5) != 0);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, N - 1),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
           (exp_q.size() != 0) && ($urandom_range(0, 2) != 0),
           $urandom);
    end
    cke = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() != 0) rsp($urandom);
      else idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
